// File: rtl/alu_issue.sv
// alu_issue: registered decode/issue stage with beq/bne resolution; `define ALU_ISSUE_TRAP_EN makes illegal instructions trap until rst
module alu_issue #(
   parameter int CMD_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_ins,
   input  logic [31:0]      in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CMD_W-1:0] out_cmd,
   output logic             out_s,
   output logic [4:0]       out_rs,
   output logic [4:0]       out_rt,
   output logic [4:0]       out_dst,
   output logic             out_wen,
   output logic             out_use_imm,
   output logic [31:0]      out_imm,
   input  logic             flag_valid,
   input  logic             ne,
   input  logic             eg,
   output logic             redirect,
   output logic [31:0]      redirect_pc,
   output logic             illegal
);
   localparam logic [1:0] RUN = 2'd0;
   localparam logic [1:0] BR_WAIT = 2'd1;
`ifdef ALU_ISSUE_TRAP_EN
   localparam logic [1:0] TRAP = 2'd2;
`endif
   localparam logic [CMD_W-1:0] C_ADD = CMD_W'(0);
   localparam logic [CMD_W-1:0] C_SUB = CMD_W'(1);
   localparam logic [CMD_W-1:0] C_AND = CMD_W'(2);
   localparam logic [CMD_W-1:0] C_OR  = CMD_W'(3);
   localparam logic [CMD_W-1:0] C_XOR = CMD_W'(4);
   localparam logic [CMD_W-1:0] C_NOR = CMD_W'(5);
   localparam logic [CMD_W-1:0] C_SLT = CMD_W'(6);

   logic [1:0]       state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [CMD_W-1:0] out_cmd_q, out_cmd_d;
   logic             out_s_q, out_s_d;
   logic [4:0]       out_rs_q, out_rs_d, out_rt_q, out_rt_d, out_dst_q, out_dst_d;
   logic             out_wen_q, out_wen_d, out_use_imm_q, out_use_imm_d;
   logic [31:0]      out_imm_q, out_imm_d, out_tgt_q, out_tgt_d;
   logic             out_br_q, out_br_d, out_bne_q, out_bne_d;
   logic [31:0]      br_tgt_q, br_tgt_d;
   logic             br_ne_q, br_ne_d;
   logic             redirect_q, redirect_d;
   logic [31:0]      redirect_pc_q, redirect_pc_d;
   logic             illegal_q, illegal_d;

   logic [5:0]       op, funct;
   logic [31:0]      imm_sext, imm_zext, dec_imm, dec_tgt;
   logic             dec_legal, dec_br, dec_s, dec_wen, dec_use_imm;
   logic [CMD_W-1:0] dec_cmd;
   logic [4:0]       dec_dst;
   logic             accept, load, bad, issue_br, resolve, taken;
   logic             unused_in;

   assign op       = in_ins[31:26];
   assign funct    = in_ins[5:0];
   assign imm_sext = {{16{in_ins[15]}}, in_ins[15:0]};
   assign imm_zext = {16'd0, in_ins[15:0]};
   assign dec_tgt  = in_pc + 32'd4 + {imm_sext[29:0], 2'b00};
   assign unused_in = ^{eg, in_ins[10:6]};

   always_comb begin
      dec_legal   = 1'b1;
      dec_br      = 1'b0;
      dec_cmd     = C_ADD;
      dec_s       = 1'b0;
      dec_wen     = 1'b1;
      dec_use_imm = 1'b1;
      dec_dst     = in_ins[20:16];
      dec_imm     = imm_sext;
      case (op)
         6'h00: begin
            dec_dst     = in_ins[15:11];
            dec_use_imm = 1'b0;
            dec_imm     = '0;
            case (funct)
               6'h20: dec_s = 1'b1;
               6'h21: dec_s = 1'b0;
               6'h22: begin dec_cmd = C_SUB; dec_s = 1'b1; end
               6'h23: dec_cmd = C_SUB;
               6'h24: dec_cmd = C_AND;
               6'h25: dec_cmd = C_OR;
               6'h26: dec_cmd = C_XOR;
               6'h27: dec_cmd = C_NOR;
               6'h2A: begin dec_cmd = C_SLT; dec_s = 1'b1; end
               6'h2B: dec_cmd = C_SLT;
               default: dec_legal = 1'b0;
            endcase
         end
         6'h08: dec_s = 1'b1;
         6'h09: dec_s = 1'b0;
         6'h0A: begin dec_cmd = C_SLT; dec_s = 1'b1; end
         6'h0B: dec_cmd = C_SLT;
         6'h0C: begin dec_cmd = C_AND; dec_imm = imm_zext; end
         6'h0D: begin dec_cmd = C_OR; dec_imm = imm_zext; end
         6'h0E: begin dec_cmd = C_XOR; dec_imm = imm_zext; end
         6'h04, 6'h05: begin
            dec_br      = 1'b1;
            dec_cmd     = C_SUB;
            dec_s       = 1'b1;
            dec_wen     = 1'b0;
            dec_use_imm = 1'b0;
         end
         default: dec_legal = 1'b0;
      endcase
   end

   // A new instruction may load in the same cycle a branch issues, so the branch is copied aside
   assign in_ready = (state_q == RUN) & (!out_valid_q | out_ready);
   assign accept   = in_valid & in_ready;
   assign load     = accept & dec_legal;
   assign bad      = accept & !dec_legal;
   assign issue_br = (state_q == RUN) & out_valid_q & out_ready & out_br_q;
   assign resolve  = (state_q == BR_WAIT) & flag_valid;
   assign taken    = br_ne_q ? ne : !ne;

   always_comb begin
`ifdef ALU_ISSUE_TRAP_EN
      state_d   = bad ? TRAP : issue_br ? BR_WAIT : resolve ? RUN : state_q;
      illegal_d = bad | (state_q == TRAP);
`else
      state_d   = issue_br ? BR_WAIT : resolve ? RUN : state_q;
      illegal_d = bad;
`endif
      out_valid_d   = load | (out_valid_q & !out_ready);
      out_cmd_d     = load ? dec_cmd : out_cmd_q;
      out_s_d       = load ? dec_s : out_s_q;
      out_rs_d      = load ? in_ins[25:21] : out_rs_q;
      out_rt_d      = load ? in_ins[20:16] : out_rt_q;
      out_dst_d     = load ? dec_dst : out_dst_q;
      out_wen_d     = load ? dec_wen : out_wen_q;
      out_use_imm_d = load ? dec_use_imm : out_use_imm_q;
      out_imm_d     = load ? dec_imm : out_imm_q;
      out_tgt_d     = load ? dec_tgt : out_tgt_q;
      out_br_d      = load ? dec_br : out_br_q;
      out_bne_d     = load ? op[0] : out_bne_q;
      br_tgt_d      = issue_br ? out_tgt_q : br_tgt_q;
      br_ne_d       = issue_br ? out_bne_q : br_ne_q;
      redirect_d    = resolve & taken;
      redirect_pc_d = (resolve & taken) ? br_tgt_q : redirect_pc_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= RUN;
         out_valid_q   <= 1'b0;
         out_cmd_q     <= '0;
         out_s_q       <= 1'b0;
         out_rs_q      <= '0;
         out_rt_q      <= '0;
         out_dst_q     <= '0;
         out_wen_q     <= 1'b0;
         out_use_imm_q <= 1'b0;
         out_imm_q     <= '0;
         out_tgt_q     <= '0;
         out_br_q      <= 1'b0;
         out_bne_q     <= 1'b0;
         br_tgt_q      <= '0;
         br_ne_q       <= 1'b0;
         redirect_q    <= 1'b0;
         redirect_pc_q <= '0;
         illegal_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         out_valid_q   <= out_valid_d;
         out_cmd_q     <= out_cmd_d;
         out_s_q       <= out_s_d;
         out_rs_q      <= out_rs_d;
         out_rt_q      <= out_rt_d;
         out_dst_q     <= out_dst_d;
         out_wen_q     <= out_wen_d;
         out_use_imm_q <= out_use_imm_d;
         out_imm_q     <= out_imm_d;
         out_tgt_q     <= out_tgt_d;
         out_br_q      <= out_br_d;
         out_bne_q     <= out_bne_d;
         br_tgt_q      <= br_tgt_d;
         br_ne_q       <= br_ne_d;
         redirect_q    <= redirect_d;
         redirect_pc_q <= redirect_pc_d;
         illegal_q     <= illegal_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_cmd     = out_cmd_q;
   assign out_s       = out_s_q;
   assign out_rs      = out_rs_q;
   assign out_rt      = out_rt_q;
   assign out_dst     = out_dst_q;
   assign out_wen     = out_wen_q;
   assign out_use_imm = out_use_imm_q;
   assign out_imm     = out_imm_q;
   assign redirect    = redirect_q;
   assign redirect_pc = redirect_pc_q;
   assign illegal     = illegal_q;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed scoreboard bench for alu_issue
module tb_alu_issue;
   logic        clk = 1'b0;
   logic        rst, in_valid, out_ready, flag_valid, ne, eg;
   logic [31:0] in_ins, in_pc;
   logic        in_ready, out_valid, out_s, out_wen, out_use_imm, redirect, illegal;
   logic [2:0]  out_cmd;
   logic [4:0]  out_rs, out_rt, out_dst;
   logic [31:0] out_imm, redirect_pc;

   typedef struct { logic [52:0] v; logic [52:0] m; } exp_t;
   exp_t        exp_q[$];
   logic [31:0] redir_q[$];
   int          tests = 0;
   int          fails = 0;

   alu_issue dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_cmd(out_cmd), .out_s(out_s), .out_rs(out_rs),
      .out_rt(out_rt), .out_dst(out_dst), .out_wen(out_wen), .out_use_imm(out_use_imm), .out_imm(out_imm),
      .flag_valid(flag_valid), .ne(ne), .eg(eg), .redirect(redirect), .redirect_pc(redirect_pc), .illegal(illegal)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [2:0] cmd, input logic s, input logic [4:0] rs, rt, dst,
                               input logic wen, ui, input logic [31:0] imm, input logic cd, ci);
      exp_t e;
      e.v = {cmd, s, rs, rt, dst, wen, ui, imm};
      e.m = {3'h7, 1'b1, 5'h1f, 5'h1f, {5{cd}}, 1'b1, 1'b1, {32{ci}}};
      return e;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] ins, input logic [31:0] pc);
      int n = 0;
      in_valid = 1'b1;
      in_ins = ins;
      in_pc = pc;
      #1;
      while (!in_ready && n < 20) begin
         cyc();
         n++;
      end
      if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic chk_zero(input string name);
      chk(name, {out_valid, out_wen, out_use_imm, out_s, redirect, illegal, out_cmd, out_rs, out_rt, out_dst}, 64'd0);
      chk({name, "_wide"}, {out_imm, redirect_pc}, 64'd0);
      chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
   endtask

   // Issue scoreboard: each handshake pops one expected operation
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         exp_t e;
         logic [52:0] a;
         a = {out_cmd, out_s, out_rs, out_rt, out_dst, out_wen, out_use_imm, out_imm};
         if (exp_q.size() == 0) chk("issue_unexpected", 64'(a), 64'd0);
         else begin
            e = exp_q.pop_front();
            chk("issue", 64'(a & e.m), 64'(e.v & e.m));
         end
      end
      if (redirect) begin
         if (redir_q.size() == 0) chk("redirect_unexpected", 64'(redirect_pc), 64'd0);
         else chk("redirect_pc", 64'(redirect_pc), 64'(redir_q.pop_front()));
      end
   end

   logic [5:0] rf [8] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27};
   logic [2:0] rc [8] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
   logic       rs_ [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_ins = '0; in_pc = '0;
      out_ready = 1'b0; flag_valid = 1'b0; ne = 1'b0; eg = 1'b0;
      cyc(); cyc();
      rst = 1'b0;
      #1;
      chk_zero("reset");

      exp_q.push_back(mk(3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0));
      send(32'h00221820, 32'h0);
      for (int i = 0; i < 4; i++) begin
         chk("add_hold", {out_valid, out_cmd, out_s, out_rs, out_rt, out_dst, out_wen, out_use_imm},
             {1'b1, 3'd0, 1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0});
         chk("add_hold_in_ready", 64'(in_ready), 64'd0);
         if (i < 3) cyc();
      end
      out_ready = 1'b1;
      cyc();

      exp_q.push_back(mk(3'd0, 1'b0, 5'd4, 5'd5, 5'd5, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b1));
      send(32'h2485FFFF, 32'h4);
      exp_q.push_back(mk(3'd3, 1'b0, 5'd0, 5'd1, 5'd1, 1'b1, 1'b1, 32'h00008000, 1'b1, 1'b1));
      send(32'h34018000, 32'h8);
      exp_q.push_back(mk(3'd6, 1'b1, 5'd7, 5'd8, 5'd8, 1'b1, 1'b1, 32'hFFFF8000, 1'b1, 1'b1));
      send({6'h0A, 5'd7, 5'd8, 16'h8000}, 32'hC);
      exp_q.push_back(mk(3'd2, 1'b0, 5'd9, 5'd10, 5'd10, 1'b1, 1'b1, 32'h0000F0F0, 1'b1, 1'b1));
      send({6'h0C, 5'd9, 5'd10, 16'hF0F0}, 32'h10);
      exp_q.push_back(mk(3'd6, 1'b0, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0));
      send(32'h0022182B, 32'h14);

      exp_q.push_back(mk(3'd1, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0));
      send(32'h10220003, 32'h100);
      cyc();
      chk("beq_wait_in_ready", 64'(in_ready), 64'd0);
      cyc(); cyc();
      chk("beq_wait2_in_ready", 64'(in_ready), 64'd0);
      flag_valid = 1'b1; ne = 1'b0;
      redir_q.push_back(32'h110);
      cyc();
      flag_valid = 1'b0;
      chk("beq_redirect", {redirect, redirect_pc}, {1'b1, 32'h110});
      chk("beq_in_ready_back", 64'(in_ready), 64'd1);
      cyc();
      chk("beq_redirect_pulse", 64'(redirect), 64'd0);

      exp_q.push_back(mk(3'd1, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0));
      send(32'h14220003, 32'h200);
      cyc();
      chk("bne_wait_in_ready", 64'(in_ready), 64'd0);
      flag_valid = 1'b1; ne = 1'b0;
      cyc();
      flag_valid = 1'b0;
      chk("bne_not_taken", {redirect, in_ready}, {1'b0, 1'b1});

      flag_valid = 1'b1; ne = 1'b1;
      cyc(); cyc();
      flag_valid = 1'b0;
      chk("flag_in_run", {redirect, in_ready}, {1'b0, 1'b1});

      send(32'hFC000000, 32'h300);
      chk("illegal_pulse", {illegal, out_valid}, {1'b1, 1'b0});
      cyc();
`ifdef ALU_ISSUE_TRAP_EN
      chk("illegal_sticky", {illegal, in_ready, out_valid}, {1'b1, 1'b0, 1'b0});
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      #1;
`endif
      chk("illegal_after", {illegal, in_ready, out_valid}, {1'b0, 1'b1, 1'b0});

      exp_q.push_back(mk(3'd1, 1'b1, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0));
      send(32'h10220003, 32'h400);
      flag_valid = 1'b1; ne = 1'b0;
      cyc();
      flag_valid = 1'b0;
      chk("flag_at_issue_ignored", {redirect, in_ready}, {1'b0, 1'b0});
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      #1;
      chk_zero("reset_mid_branch");
      flag_valid = 1'b1;
      cyc();
      flag_valid = 1'b0;
      chk("no_redirect_after_reset", 64'(redirect), 64'd0);

      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(mk(rc[i], rs_[i], 5'(i), 5'(i + 1), 5'(i + 2), 1'b1, 1'b0, 32'd0, 1'b1, 1'b0));
         send({6'h00, 5'(i), 5'(i + 1), 5'(i + 2), 5'd0, rf[i]}, 32'(i * 4));
         chk("b2b_issue", {out_valid, out_rs}, {1'b1, 5'(i)});
      end
      cyc(); cyc();
      chk("scoreboard_drained", 64'(exp_q.size() + redir_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
